// File: rtl/fft_bfly_sequencer.sv
// Radix-2 DIT FFT butterfly sequencer: walks stages/butterflies, issues
// u/v/twiddle reads, and write-backs delayed by the RAM read latency.
// Ports: clk, rst_n, start -> busy, done, stage, rd_en/rd_addr_u/rd_addr_v,
//        tw_addr, wr_en/wr_addr_u/wr_addr_v.
module fft_bfly_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_u,
  output logic [N_LOG2-1:0] rd_addr_v,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_u,
  output logic [N_LOG2-1:0] wr_addr_v
);

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int TW = N_LOG2 - 1;
  localparam int GW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef logic [AW-1:0] addr_t;
  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  localparam logic [KW-1:0] K_LAST = '1;
  localparam addr_t         S_LAST = addr_t'(N_LOG2 - 1);
  localparam logic [GW-1:0] G_LAST = GW'(RD_LAT - 1);

  state_t          state_q;
  addr_t           s_q;
  logic [KW-1:0]   k_q;
  logic [GW-1:0]   gap_q;
  logic            busy_q, done_q, rd_en_q;
  addr_t           u_q, v_q;
  logic [TW-1:0]   tw_q;

  // Addresses of the next butterfly (k_q + 1) in the current stage
  addr_t         k_d, span_d, pos_d, grp_d, u_d, v_d;
  logic [TW-1:0] tw_d;

  always_comb begin
    k_d    = {1'b0, k_q} + addr_t'(1);
    span_d = addr_t'(1) << s_q;
    pos_d  = k_d & (span_d - addr_t'(1));
    grp_d  = k_d >> s_q;
    u_d    = ((grp_d << 1) << s_q) | pos_d;
    v_d    = u_d + span_d;
    tw_d   = pos_d[TW-1:0] << (S_LAST - s_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      tw_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            s_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            u_q     <= '0;
            v_q     <= addr_t'(1);
            tw_q    <= '0;
          end
        end
        RUN: begin
          if (k_q == K_LAST) begin
            state_q <= GAP;
            k_q     <= '0;
            gap_q   <= '0;
            rd_en_q <= 1'b0;
          end else begin
            k_q     <= k_q + KW'(1);
            rd_en_q <= 1'b1;
            u_q     <= u_d;
            v_q     <= v_d;
            tw_q    <= tw_d;
          end
        end
        GAP: begin
          if (gap_q == G_LAST) begin
            if (s_q == S_LAST) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // First butterfly of the next stage: u=0, v=span, tw=0
              state_q <= RUN;
              s_q     <= s_q + addr_t'(1);
              rd_en_q <= 1'b1;
              u_q     <= '0;
              v_q     <= span_d << 1;
              tw_q    <= '0;
            end
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write-back pipe: read strobe/addresses delayed by RD_LAT cycles
  logic  wp_en [RD_LAT];
  addr_t wp_u  [RD_LAT];
  addr_t wp_v  [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        wp_en[i] <= 1'b0;
        wp_u[i]  <= '0;
        wp_v[i]  <= '0;
      end
    end else begin
      wp_en[0] <= rd_en_q;
      wp_u[0]  <= u_q;
      wp_v[0]  <= v_q;
      for (int i = 1; i < RD_LAT; i++) begin
        wp_en[i] <= wp_en[i-1];
        wp_u[i]  <= wp_u[i-1];
        wp_v[i]  <= wp_v[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = s_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_u = u_q;
  assign rd_addr_v = v_q;
  assign tw_addr   = tw_q;
  assign wr_en     = wp_en[RD_LAT-1];
  assign wr_addr_u = wp_u[RD_LAT-1];
  assign wr_addr_v = wp_v[RD_LAT-1];

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Directed testbench for fft_bfly_sequencer (N=8, RD_LAT=1 and RD_LAT=2),
// including a RAM + butterfly model for an impulse transform.
module tb_fft_bfly_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start2;
  logic       busy1, done1, rd_en1, wr_en1;
  logic [2:0] stage1, u1, v1, wu1, wv1;
  logic [1:0] tw1;
  logic       busy2, done2, rd_en2, wr_en2;
  logic [2:0] stage2, u2, v2, wu2, wv2;
  logic [1:0] tw2;

  fft_bfly_sequencer #(.N_LOG2(3), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1), .stage(stage1),
    .rd_en(rd_en1), .rd_addr_u(u1), .rd_addr_v(v1),
    .tw_addr(tw1), .wr_en(wr_en1),
    .wr_addr_u(wu1), .wr_addr_v(wv1)
  );

  fft_bfly_sequencer #(.N_LOG2(3), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .busy(busy2), .done(done2), .stage(stage2),
    .rd_en(rd_en2), .rd_addr_u(u2), .rd_addr_v(v2),
    .tw_addr(tw2), .wr_en(wr_en2),
    .wr_addr_u(wu2), .wr_addr_v(wv2)
  );

  int checks = 0;
  int errors = 0;

  // Hand-derived read sequence for N=8: stage 0, 1, 2
  int eu[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int ev[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // RAM + butterfly model (Q4.8) driven by dut1
  int re[8], im[8];
  int lur, lui, lvr, lvi, ltw;
  int twr[4] = '{256, 181, 0, -181};
  int twi[4] = '{0, -181, -256, -181};

  always @(negedge clk) begin
    int tr, ti;
    if (wr_en1) begin
      tr = (lvr * twr[ltw] - lvi * twi[ltw]) >>> 8;
      ti = (lvr * twi[ltw] + lvi * twr[ltw]) >>> 8;
      re[wu1] = lur + tr;
      im[wu1] = lui + ti;
      re[wv1] = lur - tr;
      im[wv1] = lui - ti;
    end
    if (rd_en1) begin
      lur = re[u1];
      lui = im[u1];
      lvr = re[v1];
      lvi = im[v1];
      ltw = int'(tw1);
    end
  end

  task automatic sample(input int sel,
                        output logic b, output logic d,
                        output logic re_o, output logic we,
                        output logic [2:0] st, output logic [2:0] u,
                        output logic [2:0] v, output logic [1:0] tw,
                        output logic [2:0] wu, output logic [2:0] wv);
    if (sel == 1) begin
      b = busy1; d = done1; re_o = rd_en1; we = wr_en1;
      st = stage1; u = u1; v = v1; tw = tw1; wu = wu1; wv = wv1;
    end else begin
      b = busy2; d = done2; re_o = rd_en2; we = wr_en2;
      st = stage2; u = u2; v = v2; tw = tw2; wu = wu2; wv = wv2;
    end
  endtask

  // Start a transform and check every cycle through done + one idle cycle.
  // poke pulses start during RUN and during FIN; both must be ignored.
  task automatic check_run(input int sel, input int lat, input bit poke);
    int tot, st, j, idx;
    bit hen[0:40];
    int hu[0:40], hv[0:40];
    logic b, d, r, w;
    logic [2:0] s, u, v, wu, wv;
    logic [1:0] tw;
    bit eb, ed, er, ew;
    tot = 3 * (4 + lat);
    hen[0] = 1'b0;
    if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
    for (int c = 1; c <= tot + 2; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start2 = 1'b0;
      sample(sel, b, d, r, w, s, u, v, tw, wu, wv);
      idx = 0;
      st = 0;
      if (c <= tot) begin
        st = (c - 1) / (4 + lat);
        j  = (c - 1) % (4 + lat);
        eb = 1'b1; ed = 1'b0;
        er = (j < 4);
        idx = er ? st * 4 + j : st * 4 + 3;
      end else begin
        eb = 1'b0; ed = (c == tot + 1); er = 1'b0;
      end
      hen[c] = er;
      hu[c] = eu[idx];
      hv[c] = ev[idx];
      ew = (c - lat >= 1) ? hen[c-lat] : 1'b0;
      checks += 4;
      if (b !== eb) begin
        errors++;
        $display("FAIL busy lat%0d c%0d: got %b want %b", lat, c, b, eb);
      end
      if (d !== ed) begin
        errors++;
        $display("FAIL done lat%0d c%0d: got %b want %b", lat, c, d, ed);
      end
      if (r !== er) begin
        errors++;
        $display("FAIL rd_en lat%0d c%0d: got %b want %b", lat, c, r, er);
      end
      if (w !== ew) begin
        errors++;
        $display("FAIL wr_en lat%0d c%0d: got %b want %b", lat, c, w, ew);
      end
      if (c <= tot) begin
        checks += 4;
        if (s !== st[2:0]) begin
          errors++;
          $display("FAIL stage lat%0d c%0d: got %0d want %0d", lat, c, s, st);
        end
        if (u !== eu[idx][2:0]) begin
          errors++;
          $display("FAIL rd_u lat%0d c%0d: got %0d want %0d", lat, c, u, eu[idx]);
        end
        if (v !== ev[idx][2:0]) begin
          errors++;
          $display("FAIL rd_v lat%0d c%0d: got %0d want %0d", lat, c, v, ev[idx]);
        end
        if (tw !== et[idx][1:0]) begin
          errors++;
          $display("FAIL tw lat%0d c%0d: got %0d want %0d", lat, c, tw, et[idx]);
        end
      end
      if (ew) begin
        checks += 2;
        if (wu !== hu[c-lat][2:0]) begin
          errors++;
          $display("FAIL wr_u lat%0d c%0d: got %0d want %0d", lat, c, wu, hu[c-lat]);
        end
        if (wv !== hv[c-lat][2:0]) begin
          errors++;
          $display("FAIL wr_v lat%0d c%0d: got %0d want %0d", lat, c, wv, hv[c-lat]);
        end
      end
      if (poke && (c == 2 || c == tot + 1)) begin
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
      end
    end
    if (poke) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        sample(sel, b, d, r, w, s, u, v, tw, wu, wv);
        checks++;
        if (b !== 1'b0 || d !== 1'b0 || r !== 1'b0) begin
          errors++;
          $display("FAIL ignored_start c%0d: busy %b done %b rd %b want 000",
                   c, b, d, r);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    #2;
    checks += 2;
    if ({busy1, done1, rd_en1, wr_en1, stage1, u1, v1, tw1, wu1, wv1} !== '0) begin
      errors++;
      $display("FAIL reset1: outputs %b want 0",
               {busy1, done1, rd_en1, wr_en1, stage1, u1, v1, tw1, wu1, wv1});
    end
    if ({busy2, done2, rd_en2, wr_en2, stage2, u2, v2, tw2, wu2, wv2} !== '0) begin
      errors++;
      $display("FAIL reset2: outputs %b want 0",
               {busy2, done2, rd_en2, wr_en2, stage2, u2, v2, tw2, wu2, wv2});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    start1 = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
    end
    checks++;
    if (stage1 !== 3'd1 || rd_en1 !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: stage %0d rd %b want 1 1", stage1, rd_en1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, rd_en1, wr_en1, stage1, u1, v1, tw1, wu1, wv1} !== '0) begin
      errors++;
      $display("FAIL abort_async: outputs %b want 0",
               {busy1, done1, rd_en1, wr_en1, stage1, u1, v1, tw1, wu1, wv1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || wr_en1 !== 1'b0) begin
        errors++;
        $display("FAIL abort_post c%0d: busy %b done %b wr %b want 000",
                 c, busy1, done1, wr_en1);
      end
    end
    check_run(1, 1, 1'b0);
  endtask

  task automatic test_scoreboard();
    for (int i = 0; i < 8; i++) begin
      re[i] = 0;
      im[i] = 0;
    end
    re[0] = 256;
    check_run(1, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (re[i] != 256 || im[i] != 0) begin
        errors++;
        $display("FAIL fft_out%0d: got (%0d,%0d) want (256,0)", i, re[i], im[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int nb;
    start1 = 1'b1;
    nb = 0;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (busy1 === 1'b1) nb++;
    end
    checks++;
    if (nb != 15) begin
      errors++;
      $display("FAIL b2b_busy: got %0d cycles want 15", nb);
    end
    @(posedge clk); #1;
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: done %b busy %b want 1 0", done1, busy1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy %b done %b want 0 0", busy1, done1);
    end
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || rd_en1 !== 1'b1 || u1 !== 3'd0 || v1 !== 3'd1) begin
      errors++;
      $display("FAIL b2b_restart: busy %b rd %b u %0d v %0d want 1 1 0 1",
               busy1, rd_en1, u1, v1);
    end
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (done1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_timeout: no done within 40 cycles");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    check_run(1, 1, 1'b0);
    check_run(2, 2, 1'b0);
    check_run(1, 1, 1'b1);
    test_abort();
    test_scoreboard();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
Controller for an in-place radix-2 decimation-in-time (DIT) FFT engine built around one shared combinational butterfly and a dual-port coefficient/data RAM.
- On start, it walks every stage and every butterfly.
- Each cycle it issues read addresses for the u/v operand pair and the twiddle ROM index.
- It issues the matching write-back addresses after the RAM read latency.
- It signals done when the last result has been written.
Input data is loaded into RAM in bit-reversed order before start; loading is outside this block.

Parameters:
N_LOG2, 3, log2 of FFT size N (N = 8 points by default).
RD_LAT, 1, RAM read latency in cycles (1 or 2); write-back delay for addresses and wr_en.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request; sampled only in IDLE.
busy  output  1  high while a transform is in progress.
done  output  1  one-cycle pulse after the final write.
stage  output  N_LOG2  current stage index s (for debug/scaling control).
rd_en  output  1  read strobe for the u and v RAM ports.
rd_addr_u  output  N_LOG2  u operand read address.
rd_addr_v  output  N_LOG2  v operand read address.
tw_addr  output  N_LOG2-1  twiddle ROM index, aligned with rd_addr_*.
wr_en  output  1  write-back strobe for both butterfly outputs.
wr_addr_u  output  N_LOG2  destination of out1 (u + t).
wr_addr_v  output  N_LOG2  destination of out2 (u - t).

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: state IDLE; all outputs 0; counters s and k cleared. Reset asserted mid-transform aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE: if start=1, the next state is RUN with s=0, k=0. Otherwise stay in IDLE.
- RUN:
  - One butterfly is issued per cycle: rd_en=1.
  - k increments 0..N/2-1.
  - When k=N/2-1, go to GAP with k cleared.
- GAP:
  - rd_en=0 for exactly RD_LAT cycles, so the last write of stage s lands before the first read of stage s+1.
  - On exit, if s=N_LOG2-1 go to FIN; else increment s and go to RUN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- busy: 1 in RUN and GAP, 0 in IDLE and FIN.
- Address generation for stage s, butterfly k:
  - span = 2^s
  - pos = k mod span
  - grp = k >> s
  - rd_addr_u = grp*2*span + pos
  - rd_addr_v = rd_addr_u + span
  - tw_addr = pos << (N_LOG2-1-s)
- Registering: all rd_* and tw_addr are registered outputs, valid in the same cycle as rd_en. They hold their last value when rd_en=0.
- Write-back pipeline: wr_en, wr_addr_u and wr_addr_v are rd_en, rd_addr_u and rd_addr_v delayed by exactly RD_LAT cycles through a shift pipeline. The butterfly is combinational, so its results are written in that same cycle.
- Cycle count: total busy cycles = N_LOG2*(N/2 + RD_LAT). For default parameters this is 3*(4+1) = 15.
- Start handling: start is ignored in RUN, GAP and FIN (no queuing). start held high continuously restarts a transform from IDLE after every done.
- Pipeline flush on abort: after reset or an abort, the delay pipeline is flushed, so wr_en=0 until new reads are issued.
- No address wrap-around is possible: rd_addr_v ≤ N-1 by construction. The bench asserts this.

Test Plan:
- Reset, then start pulse, N_LOG2=3, RD_LAT=1 → stage 0 reads (u,v,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0) on four consecutive cycles. Then one idle cycle.
- Same run, stages 1 and 2:
  - stage 1 reads (0,2,0), (1,3,2), (4,6,0), (5,7,2);
  - stage 2 reads (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - stage output matches on every rd_en cycle.
- Write-back alignment: every wr_en cycle carries the addresses of the read exactly RD_LAT cycles earlier. Check with RD_LAT=1 and RD_LAT=2; RD_LAT=2 gives busy for 3*(4+2) = 18 cycles.
- Done timing: busy high for 15 cycles after the start edge, done=1 in cycle 16 with busy=0. Then IDLE, with all strobes 0.
- start pulsed during RUN and during FIN → ignored: address sequence unchanged, exactly one done.
- rst_n pulled low during stage 1 → all outputs go to 0 asynchronously, no done. A fresh start after release replays the sequence from stage 0, k=0.
- Scoreboard end-to-end: with the RAM model plus butterfly (WIDTH=12, FRACTION=8), input x=[1,0,0,0,0,0,0,0] in Q4.8 (value 256, bit-reversed load) → all eight outputs real 256, imaginary 0.
